// File: rtl/lif_pkg.sv
// Shared definitions for the spike window decoder: default channel/count
// sizing, window timer width, FSM state type and window length decoding.
package lif_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TOT_W  = CNT_W + 3;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WIN_W  = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // A programmed length of 0 stands for a 256-cycle window.
    function automatic logic [WIN_W-1:0] decode_len(input logic [7:0] len);
        return (len == 8'd0) ? WIN_W'(256) : WIN_W'(len);
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : advance the counter this cycle
//   inc         : channel spiked this cycle
//   clr         : clear to zero (window boundary), overrides en
//   cnt_nxt_c   : combinational count including this cycle's spike
module spike_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_nxt_c
);

    logic [CNT_W-1:0] cnt_q;

    // Saturate at all-ones instead of wrapping.
    always_comb begin
        cnt_nxt_c = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_nxt_c = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/spike_window_decoder.sv
// Counts spikes per channel over a window of enabled cycles and reports the
// most active channel, its count and the total count through a valid/ready
// result register.
//   clk, rst_n   : clock, synchronous active-low reset
//   ena          : count enable, freezes window timer and counters when low
//   spike_in     : one spike bit per channel
//   window_len   : window length in enabled cycles, 0 means 256
//   res_ready    : consumer accepts the result
//   res_valid    : result registers hold an unconsumed result
//   winner       : lowest-index channel with the highest count
//   winner_count : count of the winning channel
//   total_count  : sum of all channel counts
//   overrun      : sticky, an unconsumed result was overwritten
module spike_window_decoder #(
    parameter int unsigned NUM_CH = lif_pkg::NUM_CH,
    parameter int unsigned CNT_W  = lif_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_CH-1:0]  spike_in,
    input  logic [7:0]         window_len,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [2:0]         winner,
    output logic [CNT_W-1:0]   winner_count,
    output logic [CNT_W+2:0]   total_count,
    output logic               overrun
);

    import lif_pkg::*;

    localparam int unsigned SUM_W = CNT_W + 3;

    state_t           state_q;
    logic [WIN_W-1:0] timer_q;
    logic [WIN_W-1:0] len_q;

    logic [WIN_W-1:0] pos;
    logic [WIN_W-1:0] cur_len;
    logic             last;

    logic [CNT_W-1:0] cnt_nxt [NUM_CH];
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [SUM_W-1:0] sum;

    // Position of the current cycle within the window; in IDLE the window
    // starts now, so its length comes straight from window_len.
    always_comb begin
        pos     = timer_q + WIN_W'(1);
        cur_len = len_q;
        if (state_q == IDLE) begin
            pos     = WIN_W'(1);
            cur_len = decode_len(window_len);
        end
        last = ena && (pos == cur_len);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (ena),
            .inc       (ena && spike_in[g]),
            .clr       (last),
            .cnt_nxt_c (cnt_nxt[g])
        );
    end

    // Argmax (strict > keeps the lowest index on ties) and total.
    always_comb begin
        best_idx = '0;
        best_cnt = '0;
        sum      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(cnt_nxt[i]);
            if (cnt_nxt[i] > best_cnt) begin
                best_cnt = cnt_nxt[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    // Window sequencing and result register with handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            len_q        <= '0;
            res_valid    <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            total_count  <= '0;
            overrun      <= 1'b0;
        end else begin
            if (ena) begin
                state_q <= COUNT;
                if (last) begin
                    timer_q <= '0;
                    len_q   <= decode_len(window_len);
                end else begin
                    timer_q <= pos;
                    len_q   <= cur_len;
                end
            end

            if (last) begin
                res_valid    <= 1'b1;
                winner       <= best_idx;
                winner_count <= best_cnt;
                total_count  <= sum;
                if (res_valid && !res_ready) begin
                    overrun <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed self-checking bench for spike_window_decoder.
module tb_spike_window_decoder;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  spike_in;
    logic [7:0]  window_len;
    logic        res_ready;
    logic        res_valid;
    logic [2:0]  winner;
    logic [7:0]  winner_count;
    logic [10:0] total_count;
    logic        overrun;

    int total;
    int bad;

    spike_window_decoder #(
        .NUM_CH (8),
        .CNT_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .spike_in     (spike_in),
        .window_len   (window_len),
        .res_ready    (res_ready),
        .res_valid    (res_valid),
        .winner       (winner),
        .winner_count (winner_count),
        .total_count  (total_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input logic [2:0] w,
                             input logic [7:0] wc, input logic [10:0] tc, input logic ov);
        check({tag, ".valid"}, 32'(res_valid), 32'(v));
        check({tag, ".winner"}, 32'(winner), 32'(w));
        check({tag, ".wcount"}, 32'(winner_count), 32'(wc));
        check({tag, ".total"}, 32'(total_count), 32'(tc));
        check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        spike_in   = 8'h00;
        window_len = 8'd4;
        res_ready  = 1'b1;

        // Reset state
        do_reset();
        check_res("reset", 1'b0, 3'd0, 8'd0, 11'd0, 1'b0);

        // Window of 4, channels 0 and 2 every cycle
        window_len = 8'd4;
        spike_in   = 8'b0000_0101;
        ena        = 1'b1;
        step(3);
        check("w4.early_valid", 32'(res_valid), 32'd0);
        step(1);
        check_res("w4", 1'b1, 3'd0, 8'd4, 11'd8, 1'b0);
        ena = 1'b0;
        step(1);
        check("w4.consumed", 32'(res_valid), 32'd0);

        // Tie between channels 2 and 5, window_len changed mid-window
        do_reset();
        window_len = 8'd6;
        ena        = 1'b1;
        spike_in   = 8'h24;
        step(2);
        window_len = 8'd2;
        step(1);
        spike_in = 8'h00;
        step(2);
        check("tie.early_valid", 32'(res_valid), 32'd0);
        step(1);
        check_res("tie", 1'b1, 3'd2, 8'd3, 11'd6, 1'b0);

        // 256-cycle window, ch7 every cycle (saturates), ch3 every other cycle
        do_reset();
        window_len = 8'd0;
        ena        = 1'b1;
        for (int i = 0; i < 255; i++) begin
            spike_in = (i % 2 == 0) ? 8'h88 : 8'h80;
            step(1);
        end
        check("w256.early_valid", 32'(res_valid), 32'd0);
        spike_in = 8'h80;
        step(1);
        check_res("w256", 1'b1, 3'd7, 8'd255, 11'd383, 1'b0);

        // Overrun: two windows of 2 with no consumer
        do_reset();
        window_len = 8'd2;
        res_ready  = 1'b0;
        ena        = 1'b1;
        spike_in   = 8'h01;
        step(2);
        check_res("ovr.first", 1'b1, 3'd0, 8'd2, 11'd2, 1'b0);
        spike_in = 8'h02;
        step(2);
        check_res("ovr.second", 1'b1, 3'd1, 8'd2, 11'd2, 1'b1);
        ena       = 1'b0;
        res_ready = 1'b1;
        step(1);
        check("ovr.consumed", 32'(res_valid), 32'd0);
        check("ovr.sticky", 32'(overrun), 32'd1);
        // All-zero window, then a load coinciding with a handshake
        res_ready = 1'b0;
        ena       = 1'b1;
        spike_in  = 8'h00;
        step(2);
        check_res("zero", 1'b1, 3'd0, 8'd0, 11'd0, 1'b1);
        spike_in = 8'h10;
        step(1);
        res_ready = 1'b1;
        step(1);
        check_res("load_hs", 1'b1, 3'd4, 8'd2, 11'd2, 1'b1);

        // ena gaps: only enabled cycles count
        do_reset();
        window_len = 8'd3;
        spike_in   = 8'h01;
        res_ready  = 1'b1;
        ena = 1'b1; step(1);
        ena = 1'b0; step(1);
        ena = 1'b1; step(1);
        ena = 1'b0; step(1);
        check("gap.early_valid", 32'(res_valid), 32'd0);
        ena = 1'b1; step(1);
        check_res("gap", 1'b1, 3'd0, 8'd3, 11'd3, 1'b0);
        ena = 1'b0;
        step(1);
        check("gap.hs_while_disabled", 32'(res_valid), 32'd0);

        // Reset mid-window discards partial counts
        do_reset();
        window_len = 8'd4;
        spike_in   = 8'h01;
        ena        = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(1);
        check_res("midrst", 1'b0, 3'd0, 8'd0, 11'd0, 1'b0);
        rst_n    = 1'b1;
        spike_in = 8'h03;
        step(3);
        check("midrst.early_valid", 32'(res_valid), 32'd0);
        step(1);
        check_res("midrst.next", 1'b1, 3'd0, 8'd4, 11'd8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
